voice_alloc: RTL and testbench

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/voice_alloc.sv | 197 +++++++++++++++++++
 tb/tb_voice_alloc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - polyphonic voice allocator: note events to per-voice gate/pitch with oldest-voice stealing
//
// Ports:
//   sample_clock, rst         clock and asynchronous active-high reset
//   evt_valid/evt_ready       event handshake; evt_op, evt_note, evt_pitch carry the event
//   panic                     all-notes-off, also aborts any event in flight
//   gate[NVOICES]             per-voice gate
//   pitch_increment           voice i in bits [i*PITCHW +: PITCHW]
//   voice_select              waveform code shared by all voices
//   steal                     one-cycle pulse when a sounding voice was reassigned
module voice_alloc #(
    parameter int NVOICES = 4,
    parameter int PITCHW  = 16
) (
    input  logic                        sample_clock,
    input  logic                        rst,
    input  logic                        evt_valid,
    output logic                        evt_ready,
    input  logic [1:0]                  evt_op,
    input  logic [6:0]                  evt_note,
    input  logic [PITCHW-1:0]           evt_pitch,
    input  logic                        panic,
    output logic [NVOICES-1:0]          gate,
    output logic [NVOICES*PITCHW-1:0]   pitch_increment,
    output logic [3:0]                  voice_select,
    output logic                        steal
);
    localparam int IW = 3;

    typedef enum logic [1:0] {S_IDLE, S_MATCH, S_RETRIG} state_t;

    localparam logic [1:0] OP_OFF  = 2'b00;
    localparam logic [1:0] OP_ON   = 2'b01;
    localparam logic [1:0] OP_WAVE = 2'b10;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [6:0]          ev_note_q, ev_note_d;
    logic [PITCHW-1:0]   ev_pitch_q, ev_pitch_d;
    logic [NVOICES-1:0]  gate_q, gate_d;
    logic [PITCHW-1:0]   pitch_q [NVOICES];
    logic [PITCHW-1:0]   pitch_d [NVOICES];
    logic [6:0]          note_q [NVOICES];
    logic [6:0]          note_d [NVOICES];
    logic [7:0]          age_q [NVOICES];
    logic [7:0]          age_d [NVOICES];
    logic [3:0]          vsel_q, vsel_d;
    logic                steal_q, steal_d;
    logic [IW-1:0]       retrig_q, retrig_d;

    logic                hit_found, free_found;
    logic [IW-1:0]       hit_idx, free_idx, old_idx, tgt_idx;
    logic [7:0]          old_age;

    assign evt_ready    = (state_q == S_IDLE) && !panic && !rst;
    assign gate         = gate_q;
    assign voice_select = vsel_q;
    assign steal        = steal_q;

    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            pitch_increment[i*PITCHW +: PITCHW] = pitch_q[i];
        end
    end

    // Target search. Descending scan so the lowest matching index wins;
    // the oldest scan uses strict '>' so ties keep the lowest index.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        old_idx    = '0;
        old_age    = age_q[0];
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && (note_q[i] == ev_note_q)) begin
                hit_found = 1'b1;
                hit_idx   = IW'(i);
            end
            if (!gate_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        for (int i = 1; i < NVOICES; i++) begin
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                old_idx = IW'(i);
            end
        end
        tgt_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ev_note_d  = ev_note_q;
        ev_pitch_d = ev_pitch_q;
        gate_d     = gate_q;
        pitch_d    = pitch_q;
        note_d     = note_q;
        age_d      = age_q;
        vsel_d     = vsel_q;
        steal_d    = 1'b0;
        retrig_d   = retrig_q;

        case (state_q)
            S_IDLE: begin
                if (evt_valid && evt_ready) begin
                    op_d       = evt_op;
                    ev_note_d  = evt_note;
                    ev_pitch_d = evt_pitch;
                    state_d    = S_MATCH;
                end
            end
            S_MATCH: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_OFF: begin
                        for (int i = 0; i < NVOICES; i++) begin
                            if (gate_q[i] && (note_q[i] == ev_note_q)) gate_d[i] = 1'b0;
                        end
                    end
                    OP_ON: begin
                        for (int i = 0; i < NVOICES; i++) begin
                            if (tgt_idx == IW'(i)) begin
                                pitch_d[i] = ev_pitch_q;
                                note_d[i]  = ev_note_q;
                                age_d[i]   = 8'd0;
                                // Retrigger and steal drop the gate for one cycle
                                // so the envelope restarts.
                                gate_d[i]  = !hit_found && free_found;
                            end else if (age_q[i] != 8'hFF) begin
                                age_d[i] = age_q[i] + 8'd1;
                            end
                        end
                        if (hit_found || !free_found) begin
                            retrig_d = tgt_idx;
                            state_d  = S_RETRIG;
                        end
                        steal_d = !hit_found && !free_found;
                    end
                    OP_WAVE: vsel_d = ev_pitch_q[3:0];
                    default: ;
                endcase
            end
            S_RETRIG: begin
                for (int i = 0; i < NVOICES; i++) begin
                    if (retrig_q == IW'(i)) gate_d[i] = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Panic wins over everything, including half-finished updates.
        if (panic) begin
            state_d = S_IDLE;
            gate_d  = '0;
            steal_d = 1'b0;
            pitch_d = pitch_q;
            note_d  = note_q;
            vsel_d  = vsel_q;
            for (int i = 0; i < NVOICES; i++) age_d[i] = 8'd0;
        end
    end

    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            ev_note_q  <= 7'd0;
            ev_pitch_q <= '0;
            gate_q     <= '0;
            vsel_q     <= 4'd0;
            steal_q    <= 1'b0;
            retrig_q   <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                pitch_q[i] <= '0;
                note_q[i]  <= 7'd0;
                age_q[i]   <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ev_note_q  <= ev_note_d;
            ev_pitch_q <= ev_pitch_d;
            gate_q     <= gate_d;
            vsel_q     <= vsel_d;
            steal_q    <= steal_d;
            retrig_q   <= retrig_d;
            pitch_q    <= pitch_d;
            note_q     <= note_d;
            age_q      <= age_d;
        end
    end
endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - scoreboard testbench for voice_alloc with a behavioural voice model
module tb_voice_alloc;
    localparam int NV = 4;
    localparam int PW = 16;

    logic              sample_clock = 1'b0;
    logic              rst = 1'b1;
    logic              evt_valid = 1'b0;
    logic              evt_ready;
    logic [1:0]        evt_op = 2'b00;
    logic [6:0]        evt_note = 7'd0;
    logic [PW-1:0]     evt_pitch = '0;
    logic              panic = 1'b0;
    logic [NV-1:0]     gate;
    logic [NV*PW-1:0]  pitch_increment;
    logic [3:0]        voice_select;
    logic              steal;

    voice_alloc #(.NVOICES(NV), .PITCHW(PW)) dut (
        .sample_clock    (sample_clock),
        .rst             (rst),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_op          (evt_op),
        .evt_note        (evt_note),
        .evt_pitch       (evt_pitch),
        .panic           (panic),
        .gate            (gate),
        .pitch_increment (pitch_increment),
        .voice_select    (voice_select),
        .steal           (steal)
    );

    always #5 sample_clock = ~sample_clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NV-1:0]    gate;
        logic [NV-1:0]    gate_mid;
        logic [NV*PW-1:0] pitch;
        logic [3:0]       vsel;
        int               steal;
        int               lat;
    } exp_t;

    exp_t sb[$];

    // Behavioural model of the voice bank
    bit m_gate [NV];
    int m_note [NV];
    int m_pitch [NV];
    int m_age [NV];
    int m_vsel = 0;

    function automatic bit will_retrig(input int op, input int note);
        bit any_free = 0;
        if (op != 1) return 0;
        for (int v = 0; v < NV; v++) begin
            if (m_gate[v] && m_note[v] == note) return 1;
            if (!m_gate[v]) any_free = 1;
        end
        return !any_free;
    endfunction

    function automatic logic [NV-1:0] pack_gate();
        logic [NV-1:0] g;
        for (int v = 0; v < NV; v++) g[v] = m_gate[v];
        return g;
    endfunction

    task automatic model_panic();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 0;
            m_age[v]  = 0;
        end
    endtask

    // mode 0: plain, 1: panic during MATCH, 2: panic during RETRIG
    task automatic model_event(input int op, input int note, input int pitch, input int mode, output exp_t e);
        int tgt = -1;
        int best = -1;
        bit retrig = 0;
        e.steal = 0;
        e.lat = 1;
        e.gate_mid = '0;
        if (mode == 1) begin
            model_panic();
        end else begin
            case (op)
                0: for (int v = 0; v < NV; v++)
                       if (m_gate[v] && m_note[v] == note) m_gate[v] = 0;
                1: begin
                    for (int v = 0; v < NV; v++)
                        if (tgt < 0 && m_gate[v] && m_note[v] == note) tgt = v;
                    if (tgt >= 0) begin
                        retrig = 1;
                    end else begin
                        for (int v = 0; v < NV; v++)
                            if (tgt < 0 && !m_gate[v]) tgt = v;
                        if (tgt < 0) begin
                            for (int v = 0; v < NV; v++)
                                if (m_age[v] > best) begin
                                    best = m_age[v];
                                    tgt = v;
                                end
                            retrig = 1;
                            e.steal = 1;
                        end
                    end
                    for (int v = 0; v < NV; v++)
                        m_age[v] = (v == tgt) ? 0 : ((m_age[v] >= 255) ? 255 : m_age[v] + 1);
                    m_pitch[tgt] = pitch;
                    m_note[tgt]  = note;
                    m_gate[tgt]  = 0;
                    e.gate_mid   = pack_gate();
                    m_gate[tgt]  = 1;
                end
                2: m_vsel = pitch % 16;
                default: ;
            endcase
            if (retrig) e.lat = 2;
            if (mode == 2) model_panic();
        end
        e.gate = pack_gate();
        for (int v = 0; v < NV; v++) e.pitch[v*PW +: PW] = PW'(m_pitch[v]);
        e.vsel = 4'(m_vsel);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!evt_ready && n < 20) begin
            @(posedge sample_clock);
            #1;
            n++;
        end
        if (!evt_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: evt_ready=%0b expected 1", evt_ready);
        end
    endtask

    task automatic send(input int op, input int note, input int pitch, input int mode_req);
        exp_t e;
        int mode = mode_req;
        wait_ready();
        if (mode == 2 && !will_retrig(op, note)) mode = 0;
        model_event(op, note, pitch, mode, e);
        sb.push_back(e);
        evt_op    = 2'(op);
        evt_note  = 7'(note);
        evt_pitch = PW'(pitch);
        evt_valid = 1'b1;
        @(posedge sample_clock);
        #1;
        evt_valid = 1'b0;
        if (mode == 1) begin
            panic = 1'b1;
            @(posedge sample_clock);
            #1;
            panic = 1'b0;
        end else if (mode == 2) begin
            @(posedge sample_clock);
            #1;
            panic = 1'b1;
            @(posedge sample_clock);
            #1;
            panic = 1'b0;
        end
    endtask

    task automatic do_panic();
        wait_ready();
        @(negedge sample_clock);
        #1;
        panic = 1'b1;
        model_panic();
        @(posedge sample_clock);
        #1;
        panic = 1'b0;
    endtask

    // Monitor: times each accepted event until evt_ready returns, then scores it
    bit   mon_busy = 0;
    int   mon_low = 0;
    int   mon_steal = 0;
    logic [NV-1:0] mon_mid = '0;
    exp_t mon_e;

    always @(negedge sample_clock) begin
        if (rst) begin
            mon_busy = 0;
        end else begin
            if (mon_busy) begin
                if (!evt_ready) begin
                    mon_low++;
                    if (steal) mon_steal++;
                    if (mon_low == 2) mon_mid = gate;
                end else begin
                    mon_busy = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow: got output with no expected entry");
                    end else begin
                        mon_e = sb.pop_front();
                        chk("gate", 64'(gate), 64'(mon_e.gate));
                        chk("pitch_increment", 64'(pitch_increment), 64'(mon_e.pitch));
                        chk("voice_select", 64'(voice_select), 64'(mon_e.vsel));
                        chk("steal_pulses", 64'(mon_steal), 64'(mon_e.steal));
                        chk("busy_cycles", 64'(mon_low), 64'(mon_e.lat));
                        if (mon_e.lat == 2) chk("gate_retrig_cycle", 64'(mon_mid), 64'(mon_e.gate_mid));
                    end
                end
            end
            if (evt_valid && evt_ready) begin
                mon_busy  = 1;
                mon_low   = 0;
                mon_steal = 0;
            end
        end
    end

    initial begin
        int r, op, mode, n;
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 0; m_note[v] = 0; m_pitch[v] = 0; m_age[v] = 0;
        end

        repeat (2) @(posedge sample_clock);
        @(negedge sample_clock);
        chk("rst_ready", 64'(evt_ready), 64'd0);
        chk("rst_gate", 64'(gate), 64'd0);
        chk("rst_pitch", 64'(pitch_increment), 64'd0);
        chk("rst_vsel", 64'(voice_select), 64'd0);
        chk("rst_steal", 64'(steal), 64'd0);
        @(posedge sample_clock);
        #1;
        rst = 1'b0;
        @(negedge sample_clock);
        chk("ready_after_rst", 64'(evt_ready), 64'd1);
        @(posedge sample_clock);
        #1;

        // Directed scenarios
        send(1, 60, 'h1234, 0);
        send(1, 62, 'h2000, 0);
        send(1, 64, 'h3000, 0);
        send(1, 65, 'h4000, 0);
        send(1, 67, 'h5555, 0);          // steals oldest voice 0
        do_panic();
        send(1, 60, 'h0100, 0);
        send(1, 62, 'h0200, 0);
        send(1, 64, 'h0300, 0);
        send(0, 62, 0, 0);               // voice 1 off, pitch kept
        send(1, 70, 'h0700, 0);          // lands on voice 1
        send(1, 70, 'h0777, 0);          // retrigger voice 1
        send(1, 72, 'h0900, 0);
        send(1, 74, 'h0A00, 1);          // panic during MATCH of a would-be steal
        send(2, 0, 'h0003, 0);
        send(3, 5, 'hBEEF, 0);
        send(1, 60, 'h1111, 0);
        send(1, 60, 'h2222, 2);          // panic during RETRIG

        // Randomised traffic over a small note range to force collisions
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 99);
            op = (r < 55) ? 1 : (r < 82) ? 0 : (r < 92) ? 2 : 3;
            mode = 0;
            r = $urandom_range(0, 99);
            if (r < 5) mode = 1;
            else if (r < 10) mode = 2;
            if ($urandom_range(0, 99) < 4) do_panic();
            send(op, 60 + $urandom_range(0, 7), $urandom_range(0, 65535), mode);
        end

        n = 0;
        while ((mon_busy || sb.size() != 0) && n < 20) begin
            @(posedge sample_clock);
            #1;
            n++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);

        // Reset in the middle of MATCH discards the event
        wait_ready();
        evt_op = 2'b01; evt_note = 7'd99; evt_pitch = 16'hABCD; evt_valid = 1'b1;
        @(posedge sample_clock);
        #1;
        evt_valid = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge sample_clock);
        chk("midrst_ready", 64'(evt_ready), 64'd0);
        chk("midrst_pitch", 64'(pitch_increment), 64'd0);
        chk("midrst_vsel", 64'(voice_select), 64'd0);
        @(posedge sample_clock);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge sample_clock);
        @(negedge sample_clock);
        chk("postrst_gate", 64'(gate), 64'd0);
        chk("postrst_pitch", 64'(pitch_increment), 64'd0);
        chk("postrst_steal", 64'(steal), 64'd0);
        chk("postrst_ready", 64'(evt_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
